// File: rtl/ym_bus_sequencer_if.sv
// ym_bus_sequencer_if
// Groups the request handshake, read return and YM/SAA bus pins of the
// sequencer into one bundle.
//   master : request source / pad side (drives req_*, d_in)
//   slave  : ym_bus_sequencer (drives req_ready, rd_*, d_out/d_oe, strobes, busy)
// Signals
//   req_valid/req_ready  request handshake, accepted on an edge with both high
//   req_tgt              0=YM0, 1=YM1, 2=SAA, 3=reserved
//   req_wr, req_a0       write/read, logical A0 (0=register number, 1=data)
//   req_wdata            write data
//   rd_valid, rd_data    one-cycle read-return pulse and held read result
//   d_in, d_out, d_oe    shared data bus d: pins in, drive value, drive enable
//   ymcs1_n, ymcs2_n     YM0 / YM1 chip selects
//   ymrd_n, ymwr_n, yma0 YM strobes and A0 (0=address, 1=data)
//   saacs_n, saawr_n     SAA chip select and write strobe
//   saaa0                SAA A0 (1=address, 0=data)
//   busy                 access in flight or any chip still recovering
interface ym_bus_sequencer_if;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_tgt;
    logic       req_wr;
    logic       req_a0;
    logic [7:0] req_wdata;
    logic       rd_valid;
    logic [7:0] rd_data;
    logic [7:0] d_in;
    logic [7:0] d_out;
    logic       d_oe;
    logic       ymcs1_n;
    logic       ymcs2_n;
    logic       ymrd_n;
    logic       ymwr_n;
    logic       yma0;
    logic       saacs_n;
    logic       saawr_n;
    logic       saaa0;
    logic       busy;

    modport master (
        output req_valid, req_tgt, req_wr, req_a0, req_wdata, d_in,
        input  req_ready, rd_valid, rd_data, d_out, d_oe,
               ymcs1_n, ymcs2_n, ymrd_n, ymwr_n, yma0,
               saacs_n, saawr_n, saaa0, busy
    );

    modport slave (
        input  req_valid, req_tgt, req_wr, req_a0, req_wdata, d_in,
        output req_ready, rd_valid, rd_data, d_out, d_oe,
               ymcs1_n, ymcs2_n, ymrd_n, ymwr_n, yma0,
               saacs_n, saawr_n, saaa0, busy
    );
endinterface

// File: rtl/ym_bus_sequencer.sv
// ym_bus_sequencer
// Runs every access on the shared YM/SAA data bus: chip select, A0, data
// drive and strobe timing, read sampling, and per-chip write recovery so a
// busy YM2203 is never strobed. Other chips may be accessed while one recovers.
// Ports
//   fclk   clock, rising edge
//   rst    asynchronous reset, active high
//   bus    ym_bus_sequencer_if.slave (request handshake, read return, bus pins)
//
// state  | meaning
// IDLE   | no access; cs_n high, d released, requests may be accepted
// SETUP  | cs/a0/data valid ahead of the strobe
// STROBE | write or read strobe low; read data sampled on last cycle
// HOLD   | strobe released, cs/a0/data still held
module ym_bus_sequencer #(
    parameter int SETUP_CYC   = 2,
    parameter int STB_CYC     = 4,
    parameter int HOLD_CYC    = 2,
    parameter int YM_ADR_WAIT = 12,
    parameter int YM_DAT_WAIT = 48,
    parameter int SAA_WAIT    = 4,
    parameter int CNTW        = 7
) (
    input logic               fclk,
    input logic               rst,
    ym_bus_sequencer_if.slave bus
);

    typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

    localparam logic [CNTW-1:0] SETUP_LD = CNTW'(SETUP_CYC - 1);
    localparam logic [CNTW-1:0] STB_LD   = CNTW'(STB_CYC - 1);
    localparam logic [CNTW-1:0] HOLD_LD  = CNTW'(HOLD_CYC - 1);
    localparam logic [CNTW-1:0] ADR_LD   = CNTW'(YM_ADR_WAIT);
    localparam logic [CNTW-1:0] DAT_LD   = CNTW'(YM_DAT_WAIT);
    localparam logic [CNTW-1:0] SAA_LD   = CNTW'(SAA_WAIT);
    localparam logic [CNTW-1:0] ONE      = CNTW'(1);

    state_t          state_q, state_d;
    logic [CNTW-1:0] ph_q, ph_d;
    logic [CNTW-1:0] rec_q [3];
    logic [CNTW-1:0] rec_d [3];
    logic [CNTW-1:0] rec_ld;
    logic [1:0]      tgt_q, tgt_d;
    logic            wr_q, wr_d;
    logic            a0_q, a0_d;
    logic            load_rec;
    logic            rec_free;
    logic            accept;
    logic            sel, stb;

    logic            cs1_n_q, cs1_n_d;
    logic            cs2_n_q, cs2_n_d;
    logic            saacs_n_q, saacs_n_d;
    logic            ymrd_n_q, ymrd_n_d;
    logic            ymwr_n_q, ymwr_n_d;
    logic            saawr_n_q, saawr_n_d;
    logic            yma0_q, yma0_d;
    logic            saaa0_q, saaa0_d;
    logic            d_oe_q, d_oe_d;
    logic [7:0]      d_out_q, d_out_d;
    logic            rd_valid_q, rd_valid_d;
    logic [7:0]      rd_data_q, rd_data_d;
    logic            busy_q, busy_d;

    // Reserved target 3 has no recovery counter and is always free.
    always_comb begin
        case (bus.req_tgt)
            2'd0:    rec_free = (rec_q[0] == '0);
            2'd1:    rec_free = (rec_q[1] == '0);
            2'd2:    rec_free = (rec_q[2] == '0);
            default: rec_free = 1'b1;
        endcase
    end

    assign bus.req_ready = (state_q == IDLE) && rec_free;
    assign accept        = bus.req_valid && bus.req_ready;

    always_comb begin
        state_d    = state_q;
        ph_d       = ph_q;
        tgt_d      = tgt_q;
        wr_d       = wr_q;
        a0_d       = a0_q;
        yma0_d     = yma0_q;
        saaa0_d    = saaa0_q;
        d_out_d    = d_out_q;
        rd_valid_d = 1'b0;
        rd_data_d  = rd_data_q;
        load_rec   = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    tgt_d = bus.req_tgt;
                    wr_d  = bus.req_wr;
                    a0_d  = bus.req_a0;
                    // SAA has no read strobe and target 3 has no chip:
                    // neither touches the bus, a read just returns FF.
                    if (bus.req_tgt == 2'd3 || (bus.req_tgt == 2'd2 && !bus.req_wr)) begin
                        if (!bus.req_wr) begin
                            rd_valid_d = 1'b1;
                            rd_data_d  = 8'hFF;
                        end
                    end else begin
                        state_d = SETUP;
                        ph_d    = SETUP_LD;
                        if (bus.req_tgt == 2'd2) saaa0_d = ~bus.req_a0;
                        else                     yma0_d  = bus.req_a0;
                        if (bus.req_wr) d_out_d = bus.req_wdata;
                    end
                end
            end
            SETUP: begin
                if (ph_q == '0) begin
                    state_d = STROBE;
                    ph_d    = STB_LD;
                end else begin
                    ph_d = ph_q - ONE;
                end
            end
            STROBE: begin
                if (ph_q == '0) begin
                    state_d = HOLD;
                    ph_d    = HOLD_LD;
                    if (!wr_q) begin
                        rd_valid_d = 1'b1;
                        rd_data_d  = bus.d_in;
                    end
                end else begin
                    ph_d = ph_q - ONE;
                end
            end
            HOLD: begin
                if (ph_q == '0) begin
                    state_d  = IDLE;
                    ph_d     = '0;
                    load_rec = wr_q;
                end else begin
                    ph_d = ph_q - ONE;
                end
            end
        endcase

        if (tgt_q == 2'd2) rec_ld = SAA_LD;
        else if (a0_q)     rec_ld = DAT_LD;
        else               rec_ld = ADR_LD;

        // Recovery counters run in every state so one chip recovers while
        // another is being accessed.
        for (int i = 0; i < 3; i++) begin
            if (load_rec && tgt_q == 2'(i)) rec_d[i] = rec_ld;
            else if (rec_q[i] != '0)       rec_d[i] = rec_q[i] - ONE;
            else                           rec_d[i] = '0;
        end

        // Pin values are derived from the next state so they are registered
        // in step with it.
        sel       = (state_d != IDLE);
        stb       = (state_d == STROBE);
        cs1_n_d   = !(sel && tgt_d == 2'd0);
        cs2_n_d   = !(sel && tgt_d == 2'd1);
        saacs_n_d = !(sel && tgt_d == 2'd2);
        ymwr_n_d  = !(stb && wr_d && tgt_d != 2'd2);
        ymrd_n_d  = !(stb && !wr_d && tgt_d != 2'd2);
        saawr_n_d = !(stb && wr_d && tgt_d == 2'd2);
        d_oe_d    = sel && wr_d;
        busy_d    = sel || (rec_d[0] != '0) || (rec_d[1] != '0) || (rec_d[2] != '0);
    end

    always_ff @(posedge fclk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            ph_q       <= '0;
            tgt_q      <= '0;
            wr_q       <= 1'b0;
            a0_q       <= 1'b0;
            for (int i = 0; i < 3; i++) rec_q[i] <= '0;
            cs1_n_q    <= 1'b1;
            cs2_n_q    <= 1'b1;
            saacs_n_q  <= 1'b1;
            ymrd_n_q   <= 1'b1;
            ymwr_n_q   <= 1'b1;
            saawr_n_q  <= 1'b1;
            yma0_q     <= 1'b0;
            saaa0_q    <= 1'b1;
            d_oe_q     <= 1'b0;
            d_out_q    <= 8'h00;
            rd_valid_q <= 1'b0;
            rd_data_q  <= 8'hFF;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ph_q       <= ph_d;
            tgt_q      <= tgt_d;
            wr_q       <= wr_d;
            a0_q       <= a0_d;
            for (int i = 0; i < 3; i++) rec_q[i] <= rec_d[i];
            cs1_n_q    <= cs1_n_d;
            cs2_n_q    <= cs2_n_d;
            saacs_n_q  <= saacs_n_d;
            ymrd_n_q   <= ymrd_n_d;
            ymwr_n_q   <= ymwr_n_d;
            saawr_n_q  <= saawr_n_d;
            yma0_q     <= yma0_d;
            saaa0_q    <= saaa0_d;
            d_oe_q     <= d_oe_d;
            d_out_q    <= d_out_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.ymcs1_n  = cs1_n_q;
    assign bus.ymcs2_n  = cs2_n_q;
    assign bus.saacs_n  = saacs_n_q;
    assign bus.ymrd_n   = ymrd_n_q;
    assign bus.ymwr_n   = ymwr_n_q;
    assign bus.saawr_n  = saawr_n_q;
    assign bus.yma0     = yma0_q;
    assign bus.saaa0    = saaa0_q;
    assign bus.d_oe     = d_oe_q;
    assign bus.d_out    = d_out_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_data  = rd_data_q;
    assign bus.busy     = busy_q;

endmodule
